obstacle_scheduler: RTL and testbench

Sequences the obstacle datapath of the game. It owns a fixed pool of obstacle slots and spawns new obstacles at a pseudo-random x on a frame-based period. Once per video frame it advances every active obstacle downward and retires obstacles that leave the playfield. It sits between the frame-timing logic (which supplies `frame_tick`) and the renderer and collision logic, which read the packed position and active vectors.

---
 rtl/obstacle_scheduler.sv | 220 ++++++++++++++++++++++
 tb/tb_obstacle_scheduler.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/obstacle_scheduler.sv
// obstacle_scheduler
//
// Owns a fixed pool of obstacle slots. Once per video frame it walks every
// slot (one per clock), pushes live obstacles down the playfield, retires
// those that would leave it, and then runs one spawn decision driven by a
// frame counter. A spawn takes the lowest free slot and places the obstacle
// at an x derived from a 16-bit Galois LFSR. The LFSR only advances on a
// successful spawn, so the x sequence depends only on the spawn history.
//
// Ports:
//   CLOCK_50        in   system clock
//   reset_n         in   asynchronous active-low reset
//   frame_tick      in   one-cycle pulse per video frame
//   enable          in   game running; low makes WAIT ignore ticks
//   clear           in   synchronous pulse removing every obstacle
//   obstacle_x      out  packed x positions, slot i at [10i+9:10i]
//   obstacle_y      out  packed y positions, same packing
//   obstacle_active out  one bit per slot, high while the slot is live
//   busy            out  high while a frame update is in progress
//   spawn_pulse     out  one-cycle pulse when an obstacle is spawned
//   spawn_miss      out  one-cycle pulse when a spawn found no free slot
module obstacle_scheduler #(
  parameter int          NUM_SLOTS    = 4,
  parameter int          SIZE_X       = 32,
  parameter int          SIZE_Y       = 32,
  parameter int          SCREEN_W     = 640,
  parameter int          SCREEN_H     = 480,
  parameter int          STEP         = 4,
  parameter int          SPAWN_PERIOD = 60,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                      CLOCK_50,
  input  logic                      reset_n,
  input  logic                      frame_tick,
  input  logic                      enable,
  input  logic                      clear,
  output logic [10*NUM_SLOTS-1:0]   obstacle_x,
  output logic [10*NUM_SLOTS-1:0]   obstacle_y,
  output logic [NUM_SLOTS-1:0]      obstacle_active,
  output logic                      busy,
  output logic                      spawn_pulse,
  output logic                      spawn_miss
);

  localparam int KW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int CW = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;
  localparam int X_LIMIT = SCREEN_W - SIZE_X;
  localparam int Y_LIMIT = SCREEN_H - SIZE_Y;
  localparam logic [KW-1:0] LAST_SLOT  = KW'(NUM_SLOTS - 1);
  localparam logic [CW-1:0] CNT_RELOAD = CW'(SPAWN_PERIOD - 1);
  localparam logic [15:0]   LFSR_TAPS  = 16'hB400;

  typedef enum logic [1:0] {
    WAIT  = 2'd0,
    MOVE  = 2'd1,
    SPAWN = 2'd2
  } state_t;

  state_t               state;
  state_t               next_state;
  logic [KW-1:0]        slot_idx;
  logic                 settle;
  logic [CW-1:0]        spawn_cnt;
  logic [15:0]          lfsr;
  logic [9:0]           pos_x [NUM_SLOTS];
  logic [9:0]           pos_y [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] slot_active;

  logic [10:0]          move_sum;
  logic                 move_retire;
  logic                 free_found;
  logic [KW-1:0]        free_idx;
  logic [9:0]           spawn_x;
  logic [15:0]          lfsr_next;
  logic                 spawn_due;

  // State register. Reset drops straight back to WAIT, even mid-update.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state <= WAIT;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. clear wins over everything; ticks are only looked at
  // in WAIT, so a tick arriving during an update is simply lost. SPAWN
  // lasts two cycles: the decision cycle, then a settle cycle in which the
  // spawn result is already visible while busy is still high.
  always_comb begin
    next_state = state;
    if (clear) begin
      next_state = WAIT;
    end else begin
      case (state)
        WAIT:    if (frame_tick && enable) next_state = MOVE;
        MOVE:    if (slot_idx == LAST_SLOT) next_state = SPAWN;
        SPAWN:   if (settle) next_state = WAIT;
        default: next_state = WAIT;
      endcase
    end
  end

  // Decode for the datapath and packing of the slot registers onto the
  // output buses. The downward sum is taken one bit wider than the position
  // so an obstacle near the bottom can never wrap back to the top. The free
  // slot search scans from the top down so the lowest free index wins.
  always_comb begin
    move_sum    = {1'b0, pos_y[slot_idx]} + 11'(STEP);
    move_retire = (move_sum > 11'(Y_LIMIT));

    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!slot_active[i]) begin
        free_found = 1'b1;
        free_idx   = KW'(i);
      end
    end

    if ({1'b0, lfsr[9:0]} >= 11'(X_LIMIT)) begin
      spawn_x = lfsr[9:0] - 10'(X_LIMIT);
    end else begin
      spawn_x = lfsr[9:0];
    end

    lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
    spawn_due = (spawn_cnt == '0);

    obstacle_x = '0;
    obstacle_y = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      obstacle_x[10*i +: 10] = pos_x[i];
      obstacle_y[10*i +: 10] = pos_y[i];
    end
    obstacle_active = slot_active;
  end

  // Datapath registers. MOVE touches one slot per cycle; SPAWN makes the
  // spawn decision on its first cycle and drops busy on its settle cycle.
  // clear wipes the pool and the spawn counter but keeps the LFSR, so the
  // x sequence continues rather than repeating after a clear.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      slot_idx    <= '0;
      settle      <= 1'b0;
      spawn_cnt   <= '0;
      lfsr        <= LFSR_SEED;
      slot_active <= '0;
      busy        <= 1'b0;
      spawn_pulse <= 1'b0;
      spawn_miss  <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        pos_x[i] <= '0;
        pos_y[i] <= '0;
      end
    end else if (clear) begin
      slot_idx    <= '0;
      settle      <= 1'b0;
      spawn_cnt   <= '0;
      slot_active <= '0;
      busy        <= 1'b0;
      spawn_pulse <= 1'b0;
      spawn_miss  <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        pos_x[i] <= '0;
        pos_y[i] <= '0;
      end
    end else begin
      spawn_pulse <= 1'b0;
      spawn_miss  <= 1'b0;
      case (state)
        WAIT: begin
          if (frame_tick && enable) begin
            busy     <= 1'b1;
            slot_idx <= '0;
          end
        end
        MOVE: begin
          if (slot_active[slot_idx]) begin
            if (move_retire) begin
              slot_active[slot_idx] <= 1'b0;
              pos_x[slot_idx]       <= '0;
              pos_y[slot_idx]       <= '0;
            end else begin
              pos_y[slot_idx] <= move_sum[9:0];
            end
          end
          slot_idx <= (slot_idx == LAST_SLOT) ? '0 : slot_idx + KW'(1);
        end
        SPAWN: begin
          if (!settle) begin
            settle <= 1'b1;
            if (spawn_due) begin
              spawn_cnt <= CNT_RELOAD;
              if (free_found) begin
                slot_active[free_idx] <= 1'b1;
                pos_x[free_idx]       <= spawn_x;
                pos_y[free_idx]       <= '0;
                lfsr                  <= lfsr_next;
                spawn_pulse           <= 1'b1;
              end else begin
                spawn_miss <= 1'b1;
              end
            end else begin
              spawn_cnt <= spawn_cnt - CW'(1);
            end
          end else begin
            settle <= 1'b0;
            busy   <= 1'b0;
          end
        end
        default: begin
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_obstacle_scheduler.sv
// tb_obstacle_scheduler
//
// Self-checking bench for obstacle_scheduler. Two instances share the
// stimulus: one with the default spawn period, one with a period of 1 for
// pool exhaustion. A behavioural model of the slot pool, spawn counter and
// LFSR predicts each frame; spawn events are queued when a tick is driven
// and matched when the DUT pulses spawn_pulse or spawn_miss.
module tb_obstacle_scheduler;

  localparam int N_SLOTS  = 4;
  localparam int MOVE_LIM = 448;
  localparam int X_LIM    = 608;
  localparam int LATENCY  = 6;

  typedef struct {
    bit miss;
    int slot;
    int x;
  } spawn_exp_t;

  logic        CLOCK_50;
  logic        reset_n;
  logic        frame_tick;
  logic        enable;
  logic        clear;
  logic [39:0] x0, y0, x1, y1;
  logic [3:0]  act0, act1;
  logic        busy0, busy1, pulse0, pulse1, miss0, miss1;

  bit          sel;
  logic [39:0] obs_x, obs_y;
  logic [3:0]  obs_active;
  logic        busy, spawn_pulse, spawn_miss;

  int checks;
  int errors;

  spawn_exp_t  sb[$];
  int          m_period;
  bit          m_act [N_SLOTS];
  int          m_x   [N_SLOTS];
  int          m_y   [N_SLOTS];
  int          m_cnt;
  logic [15:0] m_lfsr;

  obstacle_scheduler dut (
    .CLOCK_50        (CLOCK_50),
    .reset_n         (reset_n),
    .frame_tick      (frame_tick),
    .enable          (enable),
    .clear           (clear),
    .obstacle_x      (x0),
    .obstacle_y      (y0),
    .obstacle_active (act0),
    .busy            (busy0),
    .spawn_pulse     (pulse0),
    .spawn_miss      (miss0)
  );

  obstacle_scheduler #(.SPAWN_PERIOD(1)) dut_p1 (
    .CLOCK_50        (CLOCK_50),
    .reset_n         (reset_n),
    .frame_tick      (frame_tick),
    .enable          (enable),
    .clear           (clear),
    .obstacle_x      (x1),
    .obstacle_y      (y1),
    .obstacle_active (act1),
    .busy            (busy1),
    .spawn_pulse     (pulse1),
    .spawn_miss      (miss1)
  );

  assign obs_x       = sel ? x1 : x0;
  assign obs_y       = sel ? y1 : y0;
  assign obs_active  = sel ? act1 : act0;
  assign busy        = sel ? busy1 : busy0;
  assign spawn_pulse = sel ? pulse1 : pulse0;
  assign spawn_miss  = sel ? miss1 : miss0;

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  function automatic int map_x(input logic [15:0] l);
    int v;
    v = int'(l[9:0]);
    return (v >= X_LIM) ? v - X_LIM : v;
  endfunction

  task automatic model_reset(input int period);
    m_period = period;
    m_cnt    = 0;
    m_lfsr   = 16'hACE1;
    for (int i = 0; i < N_SLOTS; i++) begin
      m_act[i] = 0;
      m_x[i]   = 0;
      m_y[i]   = 0;
    end
    sb.delete();
  endtask

  task automatic model_clear();
    m_cnt = 0;
    for (int i = 0; i < N_SLOTS; i++) begin
      m_act[i] = 0;
      m_x[i]   = 0;
      m_y[i]   = 0;
    end
  endtask

  task automatic model_frame();
    spawn_exp_t e;
    int free;
    for (int i = 0; i < N_SLOTS; i++) begin
      if (m_act[i]) begin
        if (m_y[i] + 4 > MOVE_LIM) begin
          m_act[i] = 0;
          m_x[i]   = 0;
          m_y[i]   = 0;
        end else begin
          m_y[i] = m_y[i] + 4;
        end
      end
    end
    if (m_cnt == 0) begin
      m_cnt = m_period - 1;
      free  = -1;
      for (int i = N_SLOTS - 1; i >= 0; i--) if (!m_act[i]) free = i;
      if (free >= 0) begin
        m_act[free] = 1;
        m_y[free]   = 0;
        m_x[free]   = map_x(m_lfsr);
        e.miss = 0;
        e.slot = free;
        e.x    = m_x[free];
        m_lfsr = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
      end else begin
        e.miss = 1;
        e.slot = -1;
        e.x    = 0;
      end
      sb.push_back(e);
    end else begin
      m_cnt = m_cnt - 1;
    end
  endtask

  // Drives one frame tick, follows the update for a fixed window and
  // compares busy width, spawn events and the final slot state.
  task automatic run_frame(input bit en);
    spawn_exp_t  e;
    int          busy_cycles, pulse_cycles, miss_cycles, pulse_at;
    int          exp_pulses, exp_misses, q_before;
    logic [39:0] ex, ey;
    logic [3:0]  ea;
    busy_cycles = 0; pulse_cycles = 0; miss_cycles = 0; pulse_at = -1;
    exp_pulses = 0; exp_misses = 0;
    @(negedge CLOCK_50);
    enable     = en;
    frame_tick = 1'b1;
    q_before   = sb.size();
    if (en) model_frame();
    if (sb.size() > q_before) begin
      if (sb[sb.size()-1].miss) exp_misses = 1;
      else exp_pulses = 1;
    end
    @(negedge CLOCK_50);
    frame_tick = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (busy) busy_cycles++;
      if (spawn_pulse || spawn_miss) begin
        if (spawn_pulse) pulse_cycles++;
        if (spawn_miss) miss_cycles++;
        pulse_at = c;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("[TB] FAIL spawn_unexpected: got pulse=%0b miss=%0b, required no event", spawn_pulse, spawn_miss);
        end else begin
          e = sb.pop_front();
          if (spawn_miss !== e.miss) begin
            errors++;
            $display("[TB] FAIL spawn_kind: got miss=%0b, required miss=%0b", spawn_miss, e.miss);
          end else if (!e.miss) begin
            checks++;
            if (obs_active[e.slot] !== 1'b1 || obs_x[e.slot*10 +: 10] !== 10'(e.x) || obs_y[e.slot*10 +: 10] !== 10'd0) begin
              errors++;
              $display("[TB] FAIL spawn_slot%0d: got act=%0b x=%0d y=%0d, required act=1 x=%0d y=0",
                       e.slot, obs_active[e.slot], obs_x[e.slot*10 +: 10], obs_y[e.slot*10 +: 10], e.x);
            end
          end
        end
      end
      @(negedge CLOCK_50);
    end
    checks++;
    if (busy_cycles !== (en ? LATENCY : 0)) begin
      errors++;
      $display("[TB] FAIL busy_width: got %0d cycles, required %0d", busy_cycles, en ? LATENCY : 0);
    end
    checks++;
    if (pulse_cycles !== exp_pulses || miss_cycles !== exp_misses) begin
      errors++;
      $display("[TB] FAIL pulse_count: got pulse=%0d miss=%0d, required pulse=%0d miss=%0d",
               pulse_cycles, miss_cycles, exp_pulses, exp_misses);
    end
    if (exp_pulses + exp_misses > 0) begin
      checks++;
      if (pulse_at !== LATENCY - 1) begin
        errors++;
        $display("[TB] FAIL pulse_timing: got cycle %0d, required %0d", pulse_at, LATENCY - 1);
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL spawn_missing: got %0d unmatched events, required 0", sb.size());
      sb.delete();
    end
    ex = '0; ey = '0; ea = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      ex[i*10 +: 10] = 10'(m_x[i]);
      ey[i*10 +: 10] = 10'(m_y[i]);
      ea[i]          = m_act[i];
    end
    checks++;
    if (obs_active !== ea || obs_x !== ex || obs_y !== ey) begin
      errors++;
      $display("[TB] FAIL slot_state: got act=%b x=%h y=%h, required act=%b x=%h y=%h",
               obs_active, obs_x, obs_y, ea, ex, ey);
    end
  endtask

  task automatic test_reset();
    #15;
    checks++;
    if (obs_active !== 4'b0 || obs_x !== 40'b0 || obs_y !== 40'b0) begin
      errors++;
      $display("[TB] FAIL reset_slots: got act=%b x=%h y=%h, required all 0", obs_active, obs_x, obs_y);
    end
    checks++;
    if (busy !== 1'b0 || spawn_pulse !== 1'b0 || spawn_miss !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags: got busy=%b pulse=%b miss=%b, required 0", busy, spawn_pulse, spawn_miss);
    end
    @(negedge CLOCK_50);
    reset_n = 1'b1;
    model_reset(60);
  endtask

  task automatic test_first_spawn();
    run_frame(1'b1);
    checks++;
    if (obs_active !== 4'b0001 || obs_x[9:0] !== 10'd225 || obs_y[9:0] !== 10'd0) begin
      errors++;
      $display("[TB] FAIL first_spawn: got act=%b x0=%0d y0=%0d, required 0001 225 0", obs_active, obs_x[9:0], obs_y[9:0]);
    end
  endtask

  task automatic test_fall_and_retire();
    for (int n = 2; n <= 114; n++) begin
      run_frame(1'b1);
      if (n == 61) begin
        checks++;
        if (obs_active[1] !== 1'b1 || obs_x[19:10] !== 10'd16) begin
          errors++;
          $display("[TB] FAIL spawn_61: got act1=%b x1=%0d, required 1 16", obs_active[1], obs_x[19:10]);
        end
      end
      if (n == 113) begin
        checks++;
        if (obs_y[9:0] !== 10'd448 || obs_active[0] !== 1'b1) begin
          errors++;
          $display("[TB] FAIL bottom_113: got y0=%0d act0=%b, required 448 1", obs_y[9:0], obs_active[0]);
        end
      end
      if (n == 114) begin
        checks++;
        if (obs_active[0] !== 1'b0) begin
          errors++;
          $display("[TB] FAIL retire_114: got act0=%b, required 0", obs_active[0]);
        end
      end
    end
  endtask

  task automatic test_freeze();
    for (int n = 0; n < 3; n++) run_frame(1'b0);
    for (int n = 0; n < 2; n++) run_frame(1'b1);
  endtask

  task automatic test_clear_mid_move();
    int exp_x;
    @(negedge CLOCK_50);
    enable     = 1'b1;
    frame_tick = 1'b1;
    @(negedge CLOCK_50);
    frame_tick = 1'b0;
    @(negedge CLOCK_50);
    clear = 1'b1;
    @(negedge CLOCK_50);
    clear = 1'b0;
    checks++;
    if (obs_active !== 4'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL clear_effect: got act=%b busy=%b, required 0000 0", obs_active, busy);
    end
    model_clear();
    exp_x = map_x(m_lfsr);
    run_frame(1'b1);
    checks++;
    if (obs_active !== 4'b0001 || obs_x[9:0] !== 10'(exp_x)) begin
      errors++;
      $display("[TB] FAIL clear_respawn: got act=%b x0=%0d, required 0001 %0d", obs_active, obs_x[9:0], exp_x);
    end
  endtask

  task automatic test_pool_exhaustion();
    int exp_x;
    sel = 1'b1;
    @(negedge CLOCK_50);
    reset_n = 1'b0;
    @(negedge CLOCK_50);
    reset_n = 1'b1;
    model_reset(1);
    for (int n = 0; n < 4; n++) run_frame(1'b1);
    checks++;
    if (obs_active !== 4'b1111 || obs_x[9:0] !== 10'd225 || obs_x[19:10] !== 10'd16) begin
      errors++;
      $display("[TB] FAIL pool_full: got act=%b x0=%0d x1=%0d, required 1111 225 16", obs_active, obs_x[9:0], obs_x[19:10]);
    end
    run_frame(1'b1);
    @(negedge CLOCK_50);
    clear = 1'b1;
    @(negedge CLOCK_50);
    clear = 1'b0;
    model_clear();
    exp_x = map_x(m_lfsr);
    run_frame(1'b1);
    checks++;
    if (obs_x[9:0] !== 10'(exp_x)) begin
      errors++;
      $display("[TB] FAIL lfsr_after_miss: got x0=%0d, required %0d", obs_x[9:0], exp_x);
    end
  endtask

  task automatic test_async_reset();
    sel = 1'b0;
    @(negedge CLOCK_50);
    enable     = 1'b1;
    frame_tick = 1'b1;
    @(negedge CLOCK_50);
    frame_tick = 1'b0;
    @(posedge CLOCK_50);
    #5 reset_n = 1'b0;
    #1;
    checks++;
    if (obs_active !== 4'b0 || obs_x !== 40'b0 || obs_y !== 40'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_reset: got act=%b x=%h y=%h busy=%b, required all 0", obs_active, obs_x, obs_y, busy);
    end
    @(negedge CLOCK_50);
    reset_n = 1'b1;
    model_reset(60);
    run_frame(1'b1);
    checks++;
    if (obs_active !== 4'b0001 || obs_x[9:0] !== 10'd225) begin
      errors++;
      $display("[TB] FAIL reset_respawn: got act=%b x0=%0d, required 0001 225", obs_active, obs_x[9:0]);
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    sel        = 1'b0;
    reset_n    = 1'b0;
    frame_tick = 1'b0;
    enable     = 1'b0;
    clear      = 1'b0;
    model_reset(60);
    $display("[TB] starting obstacle_scheduler bench");
    test_reset();
    test_first_spawn();
    test_fall_and_retire();
    test_freeze();
    test_clear_mid_move();
    test_pool_exhaustion();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
